// File: rtl/line_capture.sv
// line_capture: synchronizes asynchronous input lines and PPS, detects masked
// rising/falling edges, timestamps them and queues {ts, level, change} words
// in a FIFO that is drained one word per rd_en request.
module line_capture #(
  parameter int NUM_LINES  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int TS_WIDTH   = 16
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic [NUM_LINES-1:0]              input_lines,
  input  logic                              pps_in,
  input  logic                              enable,
  input  logic [NUM_LINES-1:0]              rise_mask,
  input  logic [NUM_LINES-1:0]              fall_mask,
  input  logic                              rd_en,
  input  logic                              ovf_clr,
  output logic [TS_WIDTH+2*NUM_LINES-1:0]   rd_data,
  output logic                              rd_valid,
  output logic                              empty,
  output logic                              overflow,
  output logic [7:0]                        drop_count
);
  localparam int W  = TS_WIDTH + 2*NUM_LINES;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C    = CW'(FIFO_DEPTH);
  localparam logic [1:0]    PRIME_DONE = 2'd3;

  // synchronizer chain and edge-detect history
  logic [NUM_LINES-1:0] lines_s1_q, lines_s1_d;
  logic [NUM_LINES-1:0] lines_s2_q, lines_s2_d;
  logic [NUM_LINES-1:0] lines_prev_q, lines_prev_d;
  logic                 pps_s1_q, pps_s1_d;
  logic                 pps_s2_q, pps_s2_d;
  logic                 pps_prev_q, pps_prev_d;

  // control state
  logic [1:0]           prime_cnt_q, prime_cnt_d;
  logic [TS_WIDTH-1:0]  ts_q, ts_d;
  logic                 evt_vld_q, evt_vld_d;
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 rd_valid_q, rd_valid_d;
  logic [W-1:0]         rd_data_q, rd_data_d;
  logic                 ovf_q, ovf_d;
  logic [7:0]           drop_cnt_q, drop_cnt_d;

  // datapath storage (not reset)
  logic [W-1:0]         evt_word_q, evt_word_d;
  logic [W-1:0]         mem_q [FIFO_DEPTH];

  logic [NUM_LINES-1:0] change;
  logic                 primed, pps_rise, full, rd_req, wr_ok, drop;

  // next-state logic: edge detection, timestamp, FIFO bookkeeping, overflow
  always_comb begin
    lines_s1_d   = input_lines;
    lines_s2_d   = lines_s1_q;
    lines_prev_d = lines_s2_q;
    pps_s1_d     = pps_in;
    pps_s2_d     = pps_s1_q;
    pps_prev_d   = pps_s2_q;

    change   = (rise_mask & lines_s2_q & ~lines_prev_q) |
               (fall_mask & ~lines_s2_q & lines_prev_q);
    primed   = (prime_cnt_q == PRIME_DONE);
    pps_rise = pps_s2_q & ~pps_prev_q;

    prime_cnt_d = primed ? prime_cnt_q : prime_cnt_q + 2'd1;
    ts_d        = pps_rise ? '0 : ts_q + TS_WIDTH'(1);

    // every line that changed this cycle lands in the same event word
    evt_vld_d  = enable & primed & (|change);
    evt_word_d = {ts_q, lines_s2_q, change};

    // a read in the same cycle frees the slot a full-FIFO write needs
    full   = (count_q == DEPTH_C);
    rd_req = rd_en & (count_q != '0);
    wr_ok  = evt_vld_q & (~full | rd_req);
    drop   = evt_vld_q & full & ~rd_req;

    wr_ptr_d = wr_ptr_q + AW'(wr_ok);
    rd_ptr_d = rd_ptr_q + AW'(rd_req);
    case ({wr_ok, rd_req})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    rd_valid_d = rd_req;
    rd_data_d  = rd_req ? mem_q[rd_ptr_q] : rd_data_q;

    // a drop coinciding with the clear still gets recorded
    if (ovf_clr) begin
      ovf_d      = drop;
      drop_cnt_d = drop ? 8'd1 : 8'd0;
    end else begin
      ovf_d      = ovf_q | drop;
      drop_cnt_d = (drop && drop_cnt_q != 8'hFF) ? drop_cnt_q + 8'd1 : drop_cnt_q;
    end
  end

  // control and synchronizer registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rstn) begin
      lines_s1_q   <= '0;
      lines_s2_q   <= '0;
      lines_prev_q <= '0;
      pps_s1_q     <= 1'b0;
      pps_s2_q     <= 1'b0;
      pps_prev_q   <= 1'b0;
      prime_cnt_q  <= '0;
      ts_q         <= '0;
      evt_vld_q    <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
      ovf_q        <= 1'b0;
      drop_cnt_q   <= '0;
    end else begin
      lines_s1_q   <= lines_s1_d;
      lines_s2_q   <= lines_s2_d;
      lines_prev_q <= lines_prev_d;
      pps_s1_q     <= pps_s1_d;
      pps_s2_q     <= pps_s2_d;
      pps_prev_q   <= pps_prev_d;
      prime_cnt_q  <= prime_cnt_d;
      ts_q         <= ts_d;
      evt_vld_q    <= evt_vld_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      rd_valid_q   <= rd_valid_d;
      rd_data_q    <= rd_data_d;
      ovf_q        <= ovf_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  // event word staging and FIFO storage; validity is tracked by control flops
  always_ff @(posedge clk) begin
    evt_word_q <= evt_word_d;
    if (wr_ok) mem_q[wr_ptr_q] <= evt_word_q;
  end

  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign empty      = (count_q == '0);
  assign overflow   = ovf_q;
  assign drop_count = drop_cnt_q;

endmodule

// File: tb/tb_line_capture.sv
// Bench for line_capture: directed scenarios plus randomized traffic, with a
// queue-based reference model checked every cycle.
module tb_line_capture;
  localparam int NL    = 8;
  localparam int DEPTH = 16;
  localparam int TSW   = 16;
  localparam int W     = TSW + 2*NL;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [NL-1:0] input_lines = '0;
  logic          pps_in = 1'b0;
  logic          enable = 1'b1;
  logic [NL-1:0] rise_mask = '1;
  logic [NL-1:0] fall_mask = '1;
  logic          rd_en = 1'b0;
  logic          ovf_clr = 1'b0;
  logic [W-1:0]  rd_data;
  logic          rd_valid;
  logic          empty;
  logic          overflow;
  logic [7:0]    drop_count;

  line_capture #(.NUM_LINES(NL), .FIFO_DEPTH(DEPTH), .TS_WIDTH(TSW)) dut (
    .clk(clk), .rstn(rstn), .input_lines(input_lines), .pps_in(pps_in),
    .enable(enable), .rise_mask(rise_mask), .fall_mask(fall_mask),
    .rd_en(rd_en), .ovf_clr(ovf_clr), .rd_data(rd_data), .rd_valid(rd_valid),
    .empty(empty), .overflow(overflow), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Events are a queue of words; an input level sampled at clock edge k is
  // seen as synchronized two edges later, the event is formed at the next
  // edge and enters the queue one edge after that. Timestamps are the number
  // of edges since the last reset or synchronized PPS rise.
  logic [W-1:0]  mq[$];
  logic          pend_v = 1'b0;
  logic [W-1:0]  pend_w = '0;
  logic          exp_rv = 1'b0;
  logic [W-1:0]  exp_rd = '0;
  logic          exp_ovf = 1'b0;
  int            exp_drops = 0;
  int            edge_n = 0;
  int            last_rst = 0;
  int            ts_base = 0;
  logic [NL-1:0] h [3] = '{default: '0};
  logic          ph [3] = '{default: 1'b0};

  initial begin : model
    logic          rq, fl, dr;
    logic [NL-1:0] sv, pv, chg;
    logic [TSW-1:0] tsp;
    forever begin
      @(posedge clk);
      edge_n++;
      if (!rstn) begin
        mq.delete();
        pend_v = 1'b0; exp_rv = 1'b0; exp_rd = '0;
        exp_ovf = 1'b0; exp_drops = 0;
        last_rst = edge_n; ts_base = edge_n;
      end else begin
        rq = rd_en && (mq.size() > 0);
        fl = (mq.size() == DEPTH);
        exp_rv = rq;
        if (rq) exp_rd = mq.pop_front();
        dr = 1'b0;
        if (pend_v) begin
          if (!fl || rq) mq.push_back(pend_w);
          else dr = 1'b1;
        end
        if (ovf_clr) begin
          exp_ovf = dr; exp_drops = dr ? 1 : 0;
        end else if (dr) begin
          exp_ovf = 1'b1;
          if (exp_drops < 255) exp_drops++;
        end
        tsp = TSW'(edge_n - 1 - ts_base);
        if (ph[1] && !ph[2]) ts_base = edge_n;
        sv  = h[1];
        pv  = h[2];
        chg = (rise_mask & sv & ~pv) | (fall_mask & ~sv & pv);
        pend_v = enable && (edge_n >= last_rst + 4) && (chg != '0);
        pend_w = {tsp, sv, chg};
      end
      h[2] = h[1]; h[1] = h[0]; h[0] = input_lines;
      ph[2] = ph[1]; ph[1] = ph[0]; ph[0] = pps_in;
    end
  end

  // cycle-by-cycle comparison of all outputs against the model
  initial begin : cycle_chk
    forever begin
      @(posedge clk);
      #1;
      check_val("rd_valid", rd_valid, exp_rv);
      check_val("rd_data", rd_data, exp_rd);
      check_val("empty", empty, mq.size() == 0);
      check_val("overflow", overflow, exp_ovf);
      check_val("drop_count", drop_count, exp_drops);
    end
  end

  initial begin : watchdog
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus helpers ----------------
  logic [W-1:0] rd_log[$];

  task automatic do_reset();
    @(negedge clk); rstn = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic read_one(output logic v, output logic [W-1:0] d);
    @(negedge clk); rd_en = 1'b1;
    @(negedge clk); rd_en = 1'b0;
    v = rd_valid; d = rd_data;
  endtask

  task automatic drain(output int n);
    logic v; logic [W-1:0] d;
    n = 0;
    rd_log.delete();
    for (int i = 0; i < 40; i++) begin
      if (empty) break;
      read_one(v, d);
      if (v) begin n++; rd_log.push_back(d); end
    end
  endtask

  task automatic new_level();
    logic [NL-1:0] nv;
    do nv = NL'($urandom); while (nv == input_lines);
    input_lines = nv;
  endtask

  initial begin : main
    logic v; logic [W-1:0] d; int n; int hi, lo;
    logic [TSW-1:0] pts;

    // lines high through reset produce nothing once released
    input_lines = '1;
    repeat (4) @(negedge clk);
    rstn = 1'b1;
    repeat (10) @(negedge clk);
    check_val("prime_empty", empty, 1);
    read_one(v, d);
    check_val("empty_read_valid", v, 0);
    // edges while disabled are absorbed; enabling later yields nothing
    enable = 1'b0; input_lines = '0;
    repeat (6) @(negedge clk);
    enable = 1'b1;
    repeat (6) @(negedge clk);
    check_val("enable_stable_empty", empty, 1);

    // single rising edge on line 0 while ts = 0x0010
    do_reset();
    repeat (16) @(negedge clk);
    input_lines = 8'h01;
    repeat (5) @(negedge clk);
    check_val("single_not_empty", empty, 0);
    read_one(v, d);
    check_val("single_valid", v, 1);
    check_val("single_change", d[NL-1:0], 8'h01);
    check_val("single_level", d[2*NL-1:NL], 8'h01);
    check_val("single_ts_window", (d[W-1:2*NL] >= 16'h0012) && (d[W-1:2*NL] <= 16'h0014), 1);

    // several lines in one cycle, partly masked
    input_lines = 8'h00;
    repeat (6) @(negedge clk);
    drain(n);
    rise_mask = 8'h0F;
    @(negedge clk); input_lines = 8'hA5;
    repeat (6) @(negedge clk);
    read_one(v, d);
    check_val("multi_change", d[NL-1:0], 8'h05);
    check_val("multi_level", d[2*NL-1:NL], 8'hA5);
    check_val("multi_single_event", empty, 1);
    rise_mask = '1;

    // overflow: 20 events, no reads
    do_reset();
    repeat (5) @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); new_level();
    end
    repeat (6) @(negedge clk);
    check_val("ovf_flag", overflow, 1);
    check_val("ovf_drops", drop_count, 4);
    drain(n);
    check_val("ovf_read_count", n, 16);
    check_val("ovf_empty_after", empty, 1);
    @(negedge clk); ovf_clr = 1'b1;
    @(negedge clk); ovf_clr = 1'b0;
    check_val("ovf_clr_flag", overflow, 0);
    check_val("ovf_clr_drops", drop_count, 0);

    // reset with queued events discards them
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); new_level();
    end
    repeat (6) @(negedge clk);
    check_val("queued_not_empty", empty, 0);
    do_reset();
    @(negedge clk);
    check_val("rst_empty", empty, 1);
    read_one(v, d);
    check_val("rst_read_valid", v, 0);
    check_val("rst_read_data", d, 0);

    // full FIFO with simultaneous read and write
    repeat (5) @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); new_level();
    end
    repeat (6) @(negedge clk);
    check_val("full_no_drop", drop_count, 0);
    @(negedge clk); new_level();
    repeat (2) @(negedge clk);
    @(negedge clk); rd_en = 1'b1;
    @(negedge clk); rd_en = 1'b0;
    check_val("full_rw_valid", rd_valid, 1);
    repeat (3) @(negedge clk);
    check_val("full_rw_drops", drop_count, 0);
    check_val("full_rw_ovf", overflow, 0);
    check_val("full_rw_not_empty", empty, 0);
    drain(n);
    check_val("full_rw_count", n, 16);

    // randomized traffic
    do_reset();
    repeat (5) @(negedge clk);
    for (int i = 0; i < 900; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 2) == 0) input_lines = NL'($urandom);
      enable  = ($urandom_range(0, 7) != 0);
      rd_en   = (i < 450) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 1) == 0);
      ovf_clr = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 39) == 0) pps_in = ~pps_in;
      if ($urandom_range(0, 49) == 0) begin
        rise_mask = NL'($urandom);
        fall_mask = NL'($urandom);
      end
    end
    @(negedge clk);
    rd_en = 1'b0; ovf_clr = 1'b0; pps_in = 1'b0; enable = 1'b1;
    rise_mask = '1; fall_mask = '1;
    repeat (8) @(negedge clk);
    drain(n);
    check_val("rand_drained", empty, 1);

    // timestamp wrap
    do_reset();
    repeat (65520) @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      new_level();
      repeat (4) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    drain(n);
    check_val("wrap_count", n, 12);
    hi = 0; lo = 0;
    for (int i = 0; i < rd_log.size(); i++) begin
      if (rd_log[i][W-1:2*NL] >= 16'hFFC0) hi++;
      if (rd_log[i][W-1:2*NL] <  16'h0040) lo++;
      if (i > 0) begin
        pts = rd_log[i][W-1:2*NL] - rd_log[i-1][W-1:2*NL];
        check_val("wrap_delta", pts, 16'd4);
      end
    end
    check_val("wrap_seen", (hi > 0) && (lo > 0), 1);

    // PPS: event ts counts cycles from the synchronized pps edge
    @(negedge clk); pps_in = 1'b1;
    repeat (3) @(negedge clk);
    pps_in = 1'b0;
    repeat (21) @(negedge clk);
    new_level();
    repeat (6) @(negedge clk);
    read_one(v, d);
    check_val("pps_valid", v, 1);
    check_val("pps_ts", d[W-1:2*NL], 16'd23);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
